name_scroller: RTL and testbench



---
 rtl/name_scroller.sv | 118 +++++++++++
 tb/tb_name_scroller.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/name_scroller.sv
// Name sequencer: steps a character index through the current name, blanks for a
// hold period between names, and supports pause plus a debounced-by-edge skip button.
module name_scroller #(
    parameter int TICK_DIV   = 1000000,
    parameter int HOLD_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] limit,
    input  logic       pause,
    input  logic       next_btn,
    output logic [2:0] name,
    output logic [4:0] char_idx,
    output logic       blank,
    output logic       name_done
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [HW-1:0] hold_cnt;
    logic          btn_s1;
    logic          btn_s2;
    logic          btn_q;
    logic          btn_edge;
    logic          tick;

    // The prescaler may sit at its terminal value while paused, so tick is gated.
    assign tick     = (state != ST_PAUSED) && (presc == PRESC_MAX);
    assign btn_edge = btn_s2 & ~btn_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            btn_q  <= 1'b0;
        end else begin
            btn_s1 <= next_btn;
            btn_s2 <= btn_s1;
            btn_q  <= btn_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            presc     <= '0;
            hold_cnt  <= '0;
            name      <= 3'd0;
            char_idx  <= 5'd0;
            blank     <= 1'b0;
            name_done <= 1'b0;
        end else begin
            name_done <= 1'b0;
            if (btn_edge) begin
                // Button overrides any pending tick or hold in progress.
                name      <= name + 3'd1;
                char_idx  <= 5'd0;
                blank     <= 1'b0;
                name_done <= 1'b1;
                presc     <= '0;
                hold_cnt  <= '0;
                state     <= pause ? ST_PAUSED : ST_RUN;
            end else begin
                case (state)
                    ST_RUN: begin
                        presc <= tick ? '0 : presc + 1'b1;
                        if (tick) begin
                            if (char_idx < limit) begin
                                char_idx <= char_idx + 5'd1;
                            end else begin
                                state    <= ST_HOLD;
                                blank    <= 1'b1;
                                hold_cnt <= '0;
                            end
                        end else if (pause) begin
                            state <= ST_PAUSED;
                        end
                    end
                    ST_HOLD: begin
                        presc <= tick ? '0 : presc + 1'b1;
                        if (tick) begin
                            if (hold_cnt == HOLD_MAX) begin
                                name      <= name + 3'd1;
                                char_idx  <= 5'd0;
                                blank     <= 1'b0;
                                name_done <= 1'b1;
                                hold_cnt  <= '0;
                                state     <= ST_RUN;
                            end else begin
                                hold_cnt <= hold_cnt + 1'b1;
                            end
                        end
                    end
                    ST_PAUSED: begin
                        if (!pause) begin
                            state <= ST_RUN;
                        end
                    end
                    default: begin
                        state <= ST_RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_name_scroller.sv
// Directed bench for name_scroller with TICK_DIV=4, HOLD_TICKS=2; expected values are
// hand-derived edge counts from reset release or from the last button action.
module tb_name_scroller;

    logic       clk;
    logic       rst_n;
    logic [4:0] limit;
    logic       pause;
    logic       next_btn;
    logic [2:0] name;
    logic [4:0] char_idx;
    logic       blank;
    logic       name_done;

    logic [4:0] lim_tab [8];
    int         n_cmp;
    int         n_err;

    name_scroller #(
        .TICK_DIV  (4),
        .HOLD_TICKS(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .limit    (limit),
        .pause    (pause),
        .next_btn (next_btn),
        .name     (name),
        .char_idx (char_idx),
        .blank    (blank),
        .name_done(name_done)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // emulated name-length lookup
    always_comb limit = lim_tab[name];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [2:0] e_name, input logic [4:0] e_char,
                             input logic e_blank, input logic e_done);
        check({tag, ".name"}, 32'(name), 32'(e_name));
        check({tag, ".char_idx"}, 32'(char_idx), 32'(e_char));
        check({tag, ".blank"}, 32'(blank), 32'(e_blank));
        check({tag, ".name_done"}, 32'(name_done), 32'(e_done));
    endtask

    task automatic set_limits(input logic [4:0] v);
        for (int i = 0; i < 8; i++) lim_tab[i] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        pause    = 1'b0;
        next_btn = 1'b0;
        set_limits(5'd11);
        #23;
        check_out("reset", 3'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // full name walk, one step every 4 clk, then a 2-tick hold
        clk_n(3);  check("walk.pre_tick", 32'(char_idx), 32'd0);
        clk_n(1);  check("walk.first_step", 32'(char_idx), 32'd1);
        clk_n(40); check_out("walk.at_limit", 3'd0, 5'd11, 1'b0, 1'b0);
        clk_n(4);  check_out("walk.hold_enter", 3'd0, 5'd11, 1'b1, 1'b0);
        clk_n(4);  check_out("walk.hold_mid", 3'd0, 5'd11, 1'b1, 1'b0);
        clk_n(4);  check_out("walk.advance", 3'd1, 5'd0, 1'b0, 1'b1);
        clk_n(1);  check("walk.done_single", 32'(name_done), 32'd0);

        // button edge lands on the same edge as a tick: a single advance
        next_btn = 1'b1;
        clk_n(3);  check_out("btn.coincident", 3'd2, 5'd0, 1'b0, 1'b1);
        clk_n(10); check_out("btn.held", 3'd2, 5'd2, 1'b0, 1'b0);
        next_btn = 1'b0;
        clk_n(3);  check("btn.release", 32'(char_idx), 32'd3);
        clk_n(15); check_out("btn.at7", 3'd2, 5'd7, 1'b0, 1'b0);
        next_btn = 1'b1;
        clk_n(3);  check_out("btn.skip", 3'd3, 5'd0, 1'b0, 1'b1);
        clk_n(1);  check("btn.done_single", 32'(name_done), 32'd0);
        next_btn = 1'b0;
        clk_n(3);  check("btn.resume", 32'(char_idx), 32'd1);

        // pause at char 5 with one prescaler count already taken
        clk_n(16); check("pause.at5", 32'(char_idx), 32'd5);
        clk_n(1);
        pause = 1'b1;
        clk_n(20); check_out("pause.frozen", 3'd3, 5'd5, 1'b0, 1'b0);
        pause = 1'b0;
        clk_n(2);  check("pause.before_step", 32'(char_idx), 32'd5);
        clk_n(1);  check("pause.step", 32'(char_idx), 32'd6);

        // limit drops below char_idx, then button aborts the hold
        lim_tab[3] = 5'd0;
        lim_tab[4] = 5'd0;
        clk_n(3);  check_out("over.pre_tick", 3'd3, 5'd6, 1'b0, 1'b0);
        clk_n(1);  check_out("over.hold", 3'd3, 5'd6, 1'b1, 1'b0);
        next_btn = 1'b1;
        clk_n(3);  check_out("hold.btn_abort", 3'd4, 5'd0, 1'b0, 1'b1);
        next_btn = 1'b0;
        clk_n(3);  check_out("zero.pre_tick", 3'd4, 5'd0, 1'b0, 1'b0);
        clk_n(1);  check_out("zero.hold", 3'd4, 5'd0, 1'b1, 1'b0);

        // asynchronous reset in the middle of a hold, away from any edge
        clk_n(1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 3'd0, 5'd0, 1'b0, 1'b0);
        set_limits(5'd11);
        clk_n(2);
        @(negedge clk);
        rst_n = 1'b1;

        // step to name 7 with the button, then let its hold wrap to name 0
        for (int i = 0; i < 7; i++) begin
            next_btn = 1'b1;
            clk_n(3);
            check($sformatf("walk7.press%0d", i), 32'(name), 32'(i + 1));
            next_btn = 1'b0;
            clk_n(3);
        end
        clk_n(52); check_out("wrap.hold", 3'd7, 5'd11, 1'b1, 1'b0);
        clk_n(1);  check_out("wrap.advance", 3'd0, 5'd0, 1'b0, 1'b1);
        clk_n(1);  check("wrap.done_single", 32'(name_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
